// File: rtl/cartpole_step_sched.sv
// ============================================================================
// Module   : cartpole_step_sched
// Brief    : Step scheduler for PE_NUM CartPole environments; owns env state,
//            handles obs/act handshakes and auto-resets finished episodes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cartpole_step_sched #(
    parameter int PE_NUM       = 20,
    parameter int ACT_WL       = 1,
    parameter int X_WL         = 32,
    parameter int X_DOT_WL     = 32,
    parameter int THETA_WL     = 32,
    parameter int THETA_DOT_WL = 32,
    parameter int RWD_WL       = 1,
    parameter int DONE_WL      = 1,
    parameter int MAX_STEPS    = 500,
    parameter int TIMEOUT      = 64,
    parameter int SC_WL        = 9
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic [PE_NUM*X_WL-1:0]         i_init_x,
    input  logic [PE_NUM*X_DOT_WL-1:0]     i_init_x_dot,
    input  logic [PE_NUM*THETA_WL-1:0]     i_init_theta,
    input  logic [PE_NUM*THETA_DOT_WL-1:0] i_init_theta_dot,
    output logic                           o_obs_valid,
    input  logic                           i_obs_ready,
    output logic [PE_NUM*X_WL-1:0]         o_obs_x,
    output logic [PE_NUM*X_DOT_WL-1:0]     o_obs_x_dot,
    output logic [PE_NUM*THETA_WL-1:0]     o_obs_theta,
    output logic [PE_NUM*THETA_DOT_WL-1:0] o_obs_theta_dot,
    output logic [PE_NUM*RWD_WL-1:0]       o_obs_rwd,
    output logic [PE_NUM*DONE_WL-1:0]      o_obs_done,
    output logic [PE_NUM-1:0]              o_obs_trunc,
    output logic                           o_act_ready,
    input  logic                           i_act_valid,
    input  logic [PE_NUM*ACT_WL-1:0]       i_act,
    output logic                           o_cmpt_ena,
    output logic [PE_NUM*X_WL-1:0]         o_cmpt_x,
    output logic [PE_NUM*X_DOT_WL-1:0]     o_cmpt_x_dot,
    output logic [PE_NUM*THETA_WL-1:0]     o_cmpt_theta,
    output logic [PE_NUM*THETA_DOT_WL-1:0] o_cmpt_theta_dot,
    output logic [PE_NUM*ACT_WL-1:0]       o_cmpt_act,
    input  logic [PE_NUM*X_WL-1:0]         i_cmpt_x,
    input  logic [PE_NUM*X_DOT_WL-1:0]     i_cmpt_x_dot,
    input  logic [PE_NUM*THETA_WL-1:0]     i_cmpt_theta,
    input  logic [PE_NUM*THETA_DOT_WL-1:0] i_cmpt_theta_dot,
    input  logic [PE_NUM*RWD_WL-1:0]       i_cmpt_rwd,
    input  logic [PE_NUM*DONE_WL-1:0]      i_cmpt_done,
    input  logic                           i_cmpt_valid,
    output logic [31:0]                    o_ep_cnt,
    output logic                           o_err,
    output logic                           o_busy
);

    localparam int               c_WAIT_WL  = $clog2(TIMEOUT + 1);
    localparam int               c_CNT_WL   = $clog2(PE_NUM + 1);
    localparam logic [SC_WL-1:0] c_MAX_SC   = SC_WL'(MAX_STEPS);
    // Wait counter starts at 0 in the first WAIT_CMPT cycle, so the error
    // lands TIMEOUT cycles after the ISSUE cycle.
    localparam logic [c_WAIT_WL-1:0] c_WAIT_LAST = c_WAIT_WL'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESENT   = 3'd1,
        S_WAIT_ACT  = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_CMPT = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    state_t                           r_state;
    logic [c_WAIT_WL-1:0]             r_wait;
    logic                             r_stop_pend;
    logic [PE_NUM-1:0][SC_WL-1:0]     r_step_cnt;
    logic [PE_NUM*X_WL-1:0]           r_x;
    logic [PE_NUM*X_DOT_WL-1:0]       r_x_dot;
    logic [PE_NUM*THETA_WL-1:0]       r_theta;
    logic [PE_NUM*THETA_DOT_WL-1:0]   r_theta_dot;
    logic [PE_NUM*ACT_WL-1:0]         r_act;

    logic [PE_NUM-1:0]                w_done;
    logic [PE_NUM-1:0]                w_trunc;
    logic [PE_NUM*DONE_WL-1:0]        w_done_fld;
    logic [PE_NUM-1:0][SC_WL-1:0]     w_sc_inc;
    logic [PE_NUM-1:0][SC_WL-1:0]     w_nx_sc;
    logic [PE_NUM*X_WL-1:0]           w_nx_x;
    logic [PE_NUM*X_DOT_WL-1:0]       w_nx_x_dot;
    logic [PE_NUM*THETA_WL-1:0]       w_nx_theta;
    logic [PE_NUM*THETA_DOT_WL-1:0]   w_nx_theta_dot;
    logic [c_CNT_WL-1:0]              w_done_cnt;
    logic                             w_stop_any;

    assign o_obs_x          = r_x;
    assign o_obs_x_dot      = r_x_dot;
    assign o_obs_theta      = r_theta;
    assign o_obs_theta_dot  = r_theta_dot;
    assign o_cmpt_x         = r_x;
    assign o_cmpt_x_dot     = r_x_dot;
    assign o_cmpt_theta     = r_theta;
    assign o_cmpt_theta_dot = r_theta_dot;
    assign o_cmpt_act       = r_act;
    assign w_stop_any       = r_stop_pend | i_stop;

    // Per-env capture: finished envs take the init state instead of the result.
    always_comb begin
        w_done         = '0;
        w_trunc        = '0;
        w_done_fld     = '0;
        w_sc_inc       = '0;
        w_nx_sc        = '0;
        w_nx_x         = '0;
        w_nx_x_dot     = '0;
        w_nx_theta     = '0;
        w_nx_theta_dot = '0;
        w_done_cnt     = '0;
        for (int k = 0; k < PE_NUM; k++) begin
            w_sc_inc[k] = r_step_cnt[k] + SC_WL'(1);
            w_trunc[k]  = (w_sc_inc[k] == c_MAX_SC) && !(|i_cmpt_done[k*DONE_WL +: DONE_WL]);
            w_done[k]   = (|i_cmpt_done[k*DONE_WL +: DONE_WL]) || w_trunc[k];
            w_done_fld[k*DONE_WL +: DONE_WL] = DONE_WL'(w_done[k]);
            w_nx_sc[k]  = w_done[k] ? '0 : w_sc_inc[k];
            w_nx_x[k*X_WL +: X_WL] = w_done[k] ? i_init_x[k*X_WL +: X_WL]
                                               : i_cmpt_x[k*X_WL +: X_WL];
            w_nx_x_dot[k*X_DOT_WL +: X_DOT_WL] = w_done[k] ? i_init_x_dot[k*X_DOT_WL +: X_DOT_WL]
                                                           : i_cmpt_x_dot[k*X_DOT_WL +: X_DOT_WL];
            w_nx_theta[k*THETA_WL +: THETA_WL] = w_done[k] ? i_init_theta[k*THETA_WL +: THETA_WL]
                                                           : i_cmpt_theta[k*THETA_WL +: THETA_WL];
            w_nx_theta_dot[k*THETA_DOT_WL +: THETA_DOT_WL] =
                w_done[k] ? i_init_theta_dot[k*THETA_DOT_WL +: THETA_DOT_WL]
                          : i_cmpt_theta_dot[k*THETA_DOT_WL +: THETA_DOT_WL];
            w_done_cnt = w_done_cnt + c_CNT_WL'(w_done[k]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_stop_pend <= 1'b0;
            r_step_cnt  <= '0;
            r_x         <= '0;
            r_x_dot     <= '0;
            r_theta     <= '0;
            r_theta_dot <= '0;
            r_act       <= '0;
            o_obs_valid <= 1'b0;
            o_obs_rwd   <= '0;
            o_obs_done  <= '0;
            o_obs_trunc <= '0;
            o_act_ready <= 1'b0;
            o_cmpt_ena  <= 1'b0;
            o_ep_cnt    <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_cmpt_ena <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_x         <= i_init_x;
                        r_x_dot     <= i_init_x_dot;
                        r_theta     <= i_init_theta;
                        r_theta_dot <= i_init_theta_dot;
                        r_step_cnt  <= '0;
                        r_stop_pend <= 1'b0;
                        o_obs_rwd   <= '0;
                        o_obs_done  <= '0;
                        o_obs_trunc <= '0;
                        o_obs_valid <= 1'b1;
                        o_busy      <= 1'b1;
                        r_state     <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (i_stop) begin
                        o_obs_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (i_obs_ready) begin
                        o_obs_valid <= 1'b0;
                        o_act_ready <= 1'b1;
                        r_state     <= S_WAIT_ACT;
                    end
                end
                S_WAIT_ACT: begin
                    if (i_stop) begin
                        o_act_ready <= 1'b0;
                        o_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (i_act_valid) begin
                        r_act       <= i_act;
                        o_act_ready <= 1'b0;
                        o_cmpt_ena  <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wait      <= '0;
                    r_stop_pend <= w_stop_any;
                    r_state     <= S_WAIT_CMPT;
                end
                S_WAIT_CMPT: begin
                    if (i_cmpt_valid) begin
                        r_x         <= w_nx_x;
                        r_x_dot     <= w_nx_x_dot;
                        r_theta     <= w_nx_theta;
                        r_theta_dot <= w_nx_theta_dot;
                        r_step_cnt  <= w_nx_sc;
                        o_obs_rwd   <= i_cmpt_rwd;
                        o_obs_done  <= w_done_fld;
                        o_obs_trunc <= w_trunc;
                        o_ep_cnt    <= o_ep_cnt + 32'(w_done_cnt);
                        r_stop_pend <= 1'b0;
                        if (w_stop_any) begin
                            o_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            o_obs_valid <= 1'b1;
                            r_state     <= S_PRESENT;
                        end
                    end else begin
                        r_stop_pend <= w_stop_any;
                        if (r_wait == c_WAIT_LAST) begin
                            o_err   <= 1'b1;
                            r_state <= S_ERR;
                        end else begin
                            r_wait <= r_wait + c_WAIT_WL'(1);
                        end
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cartpole_step_sched.sv
// ============================================================================
// Module   : tb_cartpole_step_sched
// Brief    : Self-checking bench for cartpole_step_sched with a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cartpole_step_sched;

    localparam int PE = 20;
    localparam int W  = 32;
    localparam int VW = PE * W;

    logic          i_clk, i_rst, i_start, i_stop;
    logic [VW-1:0] i_init_x, i_init_x_dot, i_init_theta, i_init_theta_dot;
    logic          o_obs_valid, i_obs_ready;
    logic [VW-1:0] o_obs_x, o_obs_x_dot, o_obs_theta, o_obs_theta_dot;
    logic [PE-1:0] o_obs_rwd, o_obs_done, o_obs_trunc;
    logic          o_act_ready, i_act_valid;
    logic [PE-1:0] i_act;
    logic          o_cmpt_ena;
    logic [VW-1:0] o_cmpt_x, o_cmpt_x_dot, o_cmpt_theta, o_cmpt_theta_dot;
    logic [PE-1:0] o_cmpt_act;
    logic [VW-1:0] i_cmpt_x, i_cmpt_x_dot, i_cmpt_theta, i_cmpt_theta_dot;
    logic [PE-1:0] i_cmpt_rwd, i_cmpt_done;
    logic          i_cmpt_valid;
    logic [31:0]   o_ep_cnt;
    logic          o_err, o_busy;

    cartpole_step_sched dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
        .i_init_x(i_init_x), .i_init_x_dot(i_init_x_dot),
        .i_init_theta(i_init_theta), .i_init_theta_dot(i_init_theta_dot),
        .o_obs_valid(o_obs_valid), .i_obs_ready(i_obs_ready),
        .o_obs_x(o_obs_x), .o_obs_x_dot(o_obs_x_dot),
        .o_obs_theta(o_obs_theta), .o_obs_theta_dot(o_obs_theta_dot),
        .o_obs_rwd(o_obs_rwd), .o_obs_done(o_obs_done), .o_obs_trunc(o_obs_trunc),
        .o_act_ready(o_act_ready), .i_act_valid(i_act_valid), .i_act(i_act),
        .o_cmpt_ena(o_cmpt_ena), .o_cmpt_x(o_cmpt_x), .o_cmpt_x_dot(o_cmpt_x_dot),
        .o_cmpt_theta(o_cmpt_theta), .o_cmpt_theta_dot(o_cmpt_theta_dot),
        .o_cmpt_act(o_cmpt_act),
        .i_cmpt_x(i_cmpt_x), .i_cmpt_x_dot(i_cmpt_x_dot),
        .i_cmpt_theta(i_cmpt_theta), .i_cmpt_theta_dot(i_cmpt_theta_dot),
        .i_cmpt_rwd(i_cmpt_rwd), .i_cmpt_done(i_cmpt_done), .i_cmpt_valid(i_cmpt_valid),
        .o_ep_cnt(o_ep_cnt), .o_err(o_err), .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [VW-1:0] x, xd, th, thd;
        logic [PE-1:0] rwd, done, trunc;
        logic [31:0]   ep;
    } exp_t;

    typedef struct {
        logic [PE-1:0] act, dm, rm, e_done, e_trunc;
        logic [31:0]   e_ep;
        int            lat;
    } vec_t;

    exp_t          sb[$];
    vec_t          tbl[8];
    logic [VW-1:0] m_x, m_xd, m_th, m_thd;
    int            m_sc[PE];
    logic [31:0]   m_ep;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, a, e);
        end
    endtask

    task automatic chk_w(input string name, input logic [VW-1:0] a, input logic [VW-1:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, a, e);
        end
    endtask

    function automatic logic [VW-1:0] inc_all(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        r = v;
        for (int k = 0; k < PE; k++) r[k*W +: W] = v[k*W +: W] + 32'd1;
        return r;
    endfunction

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk_w("obs_x", o_obs_x, e.x);
        chk_w("obs_x_dot", o_obs_x_dot, e.xd);
        chk_w("obs_theta", o_obs_theta, e.th);
        chk_w("obs_theta_dot", o_obs_theta_dot, e.thd);
        chk("obs_rwd", 32'(o_obs_rwd), 32'(e.rwd));
        chk("obs_done", 32'(o_obs_done), 32'(e.done));
        chk("obs_trunc", 32'(o_obs_trunc), 32'(e.trunc));
        chk("ep_cnt", o_ep_cnt, e.ep);
    endtask

    task automatic model_start();
        exp_t e;
        m_x = i_init_x; m_xd = i_init_x_dot; m_th = i_init_theta; m_thd = i_init_theta_dot;
        for (int k = 0; k < PE; k++) m_sc[k] = 0;
        e.x = m_x; e.xd = m_xd; e.th = m_th; e.thd = m_thd;
        e.rwd = '0; e.done = '0; e.trunc = '0; e.ep = m_ep;
        sb.push_back(e);
    endtask

    task automatic model_capture(input logic [PE-1:0] dm, input logic [PE-1:0] rm);
        exp_t e;
        int   sc;
        logic tr, d;
        e.done = '0; e.trunc = '0;
        for (int k = 0; k < PE; k++) begin
            sc = m_sc[k] + 1;
            tr = (sc == 500) && !dm[k];
            d  = dm[k] || tr;
            e.done[k] = d; e.trunc[k] = tr;
            if (d) begin
                m_x[k*W +: W]   = i_init_x[k*W +: W];
                m_xd[k*W +: W]  = i_init_x_dot[k*W +: W];
                m_th[k*W +: W]  = i_init_theta[k*W +: W];
                m_thd[k*W +: W] = i_init_theta_dot[k*W +: W];
                m_sc[k] = 0;
                m_ep = m_ep + 32'd1;
            end else begin
                m_x[k*W +: W]   = m_x[k*W +: W] + 32'd1;
                m_xd[k*W +: W]  = m_xd[k*W +: W] + 32'd1;
                m_th[k*W +: W]  = m_th[k*W +: W] + 32'd1;
                m_thd[k*W +: W] = m_thd[k*W +: W] + 32'd1;
                m_sc[k] = sc;
            end
        end
        e.x = m_x; e.xd = m_xd; e.th = m_th; e.thd = m_thd;
        e.rwd = rm; e.ep = m_ep;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        m_ep = '0;
        sb.delete();
    endtask

    task automatic start_run();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_obs_valid", 32'(o_obs_valid), 32'd1);
        chk("start_busy", 32'(o_busy), 32'd1);
        model_start();
        pop_check();
    endtask

    // Drives the obs and act handshakes; returns in the ISSUE cycle.
    task automatic present_and_act(input logic [PE-1:0] act, input int obs_dly, input int act_dly);
        logic [VW-1:0] snap;
        int            ena_seen;
        bit            stable;
        for (int i = 0; i < 50 && !o_obs_valid; i++) tick();
        chk("obs_valid_wait", 32'(o_obs_valid), 32'd1);
        snap = o_obs_x; ena_seen = 0; stable = 1'b1;
        for (int i = 0; i < obs_dly; i++) begin
            tick();
            if (o_cmpt_ena) ena_seen++;
            if (o_obs_x !== snap || !o_obs_valid) stable = 1'b0;
        end
        i_obs_ready = 1'b1;
        tick();
        i_obs_ready = 1'b0;
        chk("act_ready", 32'(o_act_ready), 32'd1);
        chk("obs_valid_drop", 32'(o_obs_valid), 32'd0);
        for (int i = 0; i < act_dly; i++) begin
            tick();
            if (o_cmpt_ena) ena_seen++;
            if (!o_act_ready || o_obs_x !== snap) stable = 1'b0;
        end
        if (obs_dly + act_dly > 0) begin
            chk("stall_no_ena", 32'(ena_seen), 32'd0);
            chk("stall_stable", 32'(stable), 32'd1);
        end
        i_act = act;
        i_act_valid = 1'b1;
        tick();
        i_act_valid = 1'b0;
        i_act = ~act;
        chk("cmpt_ena_hi", 32'(o_cmpt_ena), 32'd1);
        chk("cmpt_act", 32'(o_cmpt_act), 32'(act));
        chk_w("cmpt_x", o_cmpt_x, m_x);
        chk_w("cmpt_theta_dot", o_cmpt_theta_dot, m_thd);
    endtask

    task automatic do_step(input logic [PE-1:0] act, input logic [PE-1:0] dm,
                           input logic [PE-1:0] rm, input int lat,
                           input int obs_dly, input int act_dly, input bit stop_wait);
        present_and_act(act, obs_dly, act_dly);
        tick();
        chk("cmpt_ena_lo", 32'(o_cmpt_ena), 32'd0);
        i_stop = stop_wait;
        tick();
        i_stop = 1'b0;
        repeat (lat - 2) tick();
        i_cmpt_x = inc_all(m_x); i_cmpt_x_dot = inc_all(m_xd);
        i_cmpt_theta = inc_all(m_th); i_cmpt_theta_dot = inc_all(m_thd);
        i_cmpt_rwd = rm; i_cmpt_done = dm;
        i_cmpt_valid = 1'b1;
        model_capture(dm, rm);
        tick();
        i_cmpt_valid = 1'b0;
        if (stop_wait) begin
            chk("stop_busy", 32'(o_busy), 32'd0);
            chk("stop_obs_valid", 32'(o_obs_valid), 32'd0);
        end else begin
            chk("capture_obs_valid", 32'(o_obs_valid), 32'd1);
        end
        pop_check();
    endtask

    initial begin
        logic [VW-1:0] ev;
        int            n;
        i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
        i_obs_ready = 1'b0; i_act_valid = 1'b0; i_act = '0;
        i_cmpt_x = '0; i_cmpt_x_dot = '0; i_cmpt_theta = '0; i_cmpt_theta_dot = '0;
        i_cmpt_rwd = '0; i_cmpt_done = '0; i_cmpt_valid = 1'b0;
        m_ep = '0;
        for (int k = 0; k < PE; k++) begin
            i_init_x[k*W +: W]         = 32'h3cc7d5cf + 32'(k) * 32'h00010000;
            i_init_x_dot[k*W +: W]     = 32'hbd000000 + 32'(k) * 32'h00000100;
            i_init_theta[k*W +: W]     = 32'h3d4ccccd ^ 32'(k);
            i_init_theta_dot[k*W +: W] = 32'hbe000000 + 32'(k) * 32'h00000010;
        end
        tbl[0] = '{20'h00000, 20'h00000, 20'hFFFFF, 20'h00000, 20'h00000, 32'd0, 3};
        tbl[1] = '{20'hFFFFF, 20'h00000, 20'h12345, 20'h00000, 20'h00000, 32'd0, 3};
        tbl[2] = '{20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 32'd0, 2};
        tbl[3] = '{20'hFFFFF, 20'h00000, 20'hFFFFF, 20'h00000, 20'h00000, 32'd0, 5};
        tbl[4] = '{20'h00000, 20'h00000, 20'hAAAAA, 20'h00000, 20'h00000, 32'd0, 3};
        tbl[5] = '{20'hFFFFF, 20'h00000, 20'h55555, 20'h00000, 20'h00000, 32'd0, 3};
        tbl[6] = '{20'h00000, 20'h00020, 20'hFFFFF, 20'h00020, 20'h00000, 32'd1, 3};
        tbl[7] = '{20'hFFFFF, 20'h00000, 20'hFFFFF, 20'h00000, 20'h00000, 32'd1, 4};

        tick();
        tick();
        chk("rst_obs_valid", 32'(o_obs_valid), 32'd0);
        chk("rst_act_ready", 32'(o_act_ready), 32'd0);
        chk("rst_cmpt_ena", 32'(o_cmpt_ena), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_ep_cnt", o_ep_cnt, 32'd0);
        chk_w("rst_obs_x", o_obs_x, '0);
        i_rst = 1'b0;
        tick();

        start_run();
        for (int i = 0; i < 8; i++) begin
            do_step(tbl[i].act, tbl[i].dm, tbl[i].rm, tbl[i].lat, 0, 0, 1'b0);
            chk("tbl_done", 32'(o_obs_done), 32'(tbl[i].e_done));
            chk("tbl_trunc", 32'(o_obs_trunc), 32'(tbl[i].e_trunc));
            chk("tbl_rwd", 32'(o_obs_rwd), 32'(tbl[i].rm));
            chk("tbl_ep_cnt", o_ep_cnt, tbl[i].e_ep);
            if (i == 6) chk("env5_x_reinit", o_obs_x[5*W +: W], i_init_x[5*W +: W]);
        end

        do_step(20'h0F0F0, 20'h00000, 20'h00001, 3, 10, 5, 1'b0);

        do_reset();
        start_run();
        for (int s = 1; s <= 500; s++) begin
            do_step(s[0] ? 20'hFFFFF : 20'h00000, 20'h00000, 20'h0F0F0, 2, 0, 0, 1'b0);
            if (s == 500) begin
                chk("trunc_done_all", 32'(o_obs_done), 32'h000FFFFF);
                chk("trunc_flag_all", 32'(o_obs_trunc), 32'h000FFFFF);
                chk("trunc_ep_cnt", o_ep_cnt, 32'd20);
                chk_w("trunc_reinit_x", o_obs_x, i_init_x);
            end
        end
        do_step(20'h00000, 20'h00000, 20'h00000, 2, 0, 0, 1'b0);
        for (int k = 0; k < PE; k++) ev[k*W +: W] = i_init_x[k*W +: W] + 32'd1;
        chk_w("post_trunc_x", o_obs_x, ev);
        chk("post_trunc_done", 32'(o_obs_done), 32'd0);

        do_step(20'h11111, 20'h00000, 20'h00003, 3, 0, 0, 1'b1);
        tick();
        chk("stop_stays_idle", 32'(o_obs_valid), 32'd0);

        start_run();
        present_and_act(20'h00000, 0, 0);
        tick();
        i_rst = 1'b1;
        tick();
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_ena", 32'(o_cmpt_ena), 32'd0);
        chk("mid_rst_ep_cnt", o_ep_cnt, 32'd0);
        chk_w("mid_rst_obs_x", o_obs_x, '0);
        chk("mid_rst_cmpt_act", 32'(o_cmpt_act), 32'd0);
        i_rst = 1'b0;
        m_ep = '0;
        sb.delete();
        i_cmpt_done = '1; i_cmpt_valid = 1'b1;
        tick();
        i_cmpt_valid = 1'b0; i_cmpt_done = '0;
        tick();
        chk("late_valid_ignored", 32'(o_obs_valid), 32'd0);
        chk("late_valid_ep", o_ep_cnt, 32'd0);

        start_run();
        present_and_act(20'hFFFFF, 0, 0);
        n = 0;
        while (!o_err && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd64);
        i_start = 1'b1; i_cmpt_valid = 1'b1;
        tick();
        i_start = 1'b0; i_cmpt_valid = 1'b0;
        tick();
        chk("err_sticky", 32'(o_err), 32'd1);
        chk("err_busy", 32'(o_busy), 32'd1);
        chk("err_no_obs", 32'(o_obs_valid), 32'd0);
        do_reset();
        chk("err_cleared", 32'(o_err), 32'd0);
        chk("err_rst_busy", 32'(o_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cartpole_step_sched.md
# cartpole_step_sched

Batch step scheduler that sequences `Cartpole_Step_Compute` for PE_NUM parallel CartPole environments. It owns the environment state registers and exchanges observation/action handshakes with the agent. Each step it issues one compute request and captures the result. Environments that terminate or hit the step limit are auto-reset from externally supplied initial states. It sits between the agent/host interface and the compute array; the compute array stays stateless.

## Interface
- PE_NUM, 20, number of parallel environments
- ACT_WL, 1, action width per env
- X_WL / X_DOT_WL / THETA_WL / THETA_DOT_WL, 32, fp32 state field widths
- RWD_WL / DONE_WL, 1, reward / done width per env
- MAX_STEPS, 500, truncation limit per episode
- TIMEOUT, 64, max cycles to wait for compute valid
- SC_WL, 9, step counter width (≥ clog2(MAX_STEPS+1))

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  pulse; load initial states and start (IDLE only)
- i_stop  in  1  pulse; return to IDLE at next step boundary
- i_init_x / i_init_x_dot / i_init_theta / i_init_theta_dot  in  PE_NUM*field_WL  reset states, sampled on load/auto-reset
- o_obs_valid  out  1  observation available
- i_obs_ready  in  1  agent accepts observation
- o_obs_x / o_obs_x_dot / o_obs_theta / o_obs_theta_dot  out  PE_NUM*field_WL  current states
- o_obs_rwd  out  PE_NUM*RWD_WL  reward of last step
- o_obs_done  out  PE_NUM*DONE_WL  terminated or truncated on last step
- o_obs_trunc  out  PE_NUM  truncated by MAX_STEPS
- o_act_ready  out  1  ready for action
- i_act_valid  in  1  action valid
- i_act  in  PE_NUM*ACT_WL  actions
- o_cmpt_ena  out  1  compute start pulse
- o_cmpt_x … o_cmpt_theta_dot, o_cmpt_act  out  packed  compute operands
- i_cmpt_x … i_cmpt_theta_dot, i_cmpt_rwd, i_cmpt_done, i_cmpt_valid  in  packed  compute results
- o_ep_cnt  out  32  completed episodes, wraps
- o_err  out  1  compute timeout, sticky
- o_busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, PRESENT, WAIT_ACT, ISSUE, WAIT_CMPT, ERR.
- IDLE: on i_start, load the state regs from i_init_*, clear step_cnt[ ], clear rwd/done/trunc, then go to PRESENT.
- PRESENT: o_obs_valid=1. On i_obs_ready, go to WAIT_ACT. If i_stop is seen, go to IDLE (stop has priority).
- WAIT_ACT: o_act_ready=1. On i_act_valid, latch i_act and go to ISSUE. i_stop also goes to IDLE here.
- ISSUE: o_cmpt_ena=1 for exactly one cycle, then go to WAIT_CMPT.
- WAIT_CMPT: o_cmpt_* are held stable from ISSUE until capture. On i_cmpt_valid, for each env k:
  - sc = step_cnt[k]+1
  - trunc[k] = (sc == MAX_STEPS) & ~i_cmpt_done[k]
  - done[k] = i_cmpt_done[k] | trunc[k]
  - rwd[k] = i_cmpt_rwd[k]
  - if done[k]: state[k] ← i_init_*[k] and step_cnt[k] ← 0; else state[k] ← i_cmpt_*[k] and step_cnt[k] ← sc
  - o_ep_cnt += popcount(done)
  - then go to PRESENT, or to IDLE if an i_stop was latched during ISSUE/WAIT_CMPT.
- Timeout: a wait counter clears in ISSUE. If it reaches TIMEOUT in WAIT_CMPT without valid, go to ERR with o_err=1. ERR exits only via i_rst.
- i_start outside IDLE is ignored. i_cmpt_valid outside WAIT_CMPT is ignored.

## Timing
- Reset: every output is 0, the FSM is in IDLE, and all state regs, counters and flags are cleared.
- i_start seen at edge N gives o_obs_valid=1 from cycle N+1.
- Handshakes are registered: a transfer occurs on the edge where valid&ready are both 1. Each side deasserts the cycle after its transfer.
- Act-accept edge A: o_cmpt_ena is high in cycle A+1.
- Capture on i_cmpt_valid edge C: o_obs_* are updated and o_obs_valid=1 in cycle C+1.
- Minimum step loop with zero agent delay: 4 cycles plus compute latency.
- Reset mid-operation: the next cycle is IDLE and in-flight results are discarded.

## Test plan
- Start with the fixed init vectors (env0 x=0x3cc7d5cf), actions alternating 0/1, model compute returns x+1ulp after 3 cycles -> o_cmpt_ena pulses once per step; obs equals the model output; done=0.
- Model sets i_cmpt_done[5]=1 at step 7 -> obs env5 equals i_init_*[5], o_obs_done[5]=1, trunc[5]=0, o_ep_cnt=1; other envs keep computed states.
- Run 500 steps with done never asserted -> step 500 has all o_obs_done=1 and o_obs_trunc=all 1, o_ep_cnt=20, step_cnt returns to 0.
- Hold i_obs_ready low for 10 cycles, then i_act_valid low for 5 cycles -> no o_cmpt_ena; obs and act stay stable.
- Model never returns valid -> o_err=1 exactly TIMEOUT cycles after ISSUE; only i_rst clears it.
- i_stop during WAIT_CMPT, then i_rst asserted mid-step on a later run -> first case: capture completes, then IDLE with o_busy=0; second case: all outputs are 0 on the next cycle.
